// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: data width, FSM states and
// the prefetch FIFO entry layout.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of {pc, instr} entries with flush.
// Head reads as zero while empty so the decode-side outputs never show stale data.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [XLEN-1:0]  push_pc,
  input  logic [XLEN-1:0]  push_instr,
  input  logic             pop,
  output logic [XLEN-1:0]  head_pc,
  output logic [XLEN-1:0]  head_instr,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  fetch_entry_t     head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
  end

  assign head       = empty ? '0 : mem[rd_ptr];
  assign head_pc    = head.pc;
  assign head_instr = head.instr;
  assign count      = cnt;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory request FSM feeding a
// prefetch FIFO, with redirect flush. INSTR_FETCH_PERF_EN adds perf counters.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded
`endif
);

  localparam int unsigned       CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic [XLEN-1:0] req_addr, req_addr_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_after;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_addr <= req_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    push         = 1'b0;
    pop          = if_valid && if_ready && !redirect;
    cnt_after    = cnt + CNT_W'(1) - CNT_W'(pop);

    if (redirect) fetch_pc_nxt = word_align(redirect_pc);

    case (state)
      S_IDLE: begin
        if (redirect || cnt < DEPTH_C) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (redirect) begin
          // an acked response is simply dropped; an unacked one must be drained
          state_nxt = imem_ack ? S_REQ : S_DISCARD;
        end else if (imem_ack) begin
          push         = 1'b1;
          fetch_pc_nxt = fetch_pc + 32'd4;
          state_nxt    = (cnt_after < DEPTH_C) ? S_REQ : S_IDLE;
        end
      end
      S_DISCARD: begin
        if (imem_ack) state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase

    // address only moves when a new request starts; DISCARD keeps the old one
    req_addr_nxt = (state_nxt == S_REQ) ? fetch_pc_nxt : req_addr;
  end

  assign imem_req  = (state != S_IDLE);
  assign imem_addr = req_addr;
  assign if_valid  = !fifo_empty;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clear      (redirect),
    .push       (push),
    .push_pc    (fetch_pc),
    .push_instr (imem_rdata),
    .pop        (pop),
    .head_pc    (if_pc),
    .head_instr (if_instr),
    .count      (cnt),
    .empty      (fifo_empty)
  );

`ifdef INSTR_FETCH_PERF_EN
  logic drop;

  assign drop = imem_ack && ((state == S_DISCARD) || (state == S_REQ && redirect));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
    end else begin
      if (push) perf_fetched   <= perf_fetched + 32'd1;
      if (drop) perf_discarded <= perf_discarded + 32'd1;
    end
  end
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DEPTH, default 4, prefetch FIFO entries, power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  word-aligned read address; bits [1:0] always 0.
REQ-007 imem_ack  input  1  request accepted; imem_rdata valid in the same cycle.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 if_valid  output  1  if_instr and if_pc valid for the processor decode stage.
REQ-010 if_ready  input  1  decode stage consumes the head entry.
REQ-011 if_instr  output  32  head instruction.
REQ-012 if_pc  output  32  address of the head instruction.
REQ-013 redirect  input  1  branch/jump taken; flush and refetch.
REQ-014 redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 0.

Function
REQ-015 FSM states: IDLE (no request), REQ (imem_req=1, awaiting ack), DISCARD (imem_req=1, response to be dropped).
REQ-016 Request protocol: once imem_req rises, it stays high and imem_addr stays stable until the cycle imem_ack=1; at most one request is outstanding.
REQ-017 IDLE->REQ when FIFO count < DEPTH; the request is issued in the first such cycle.
REQ-018 In REQ, on imem_ack: push {fetch_pc, imem_rdata}; fetch_pc += 4, wrapping modulo 2^32; go to REQ if count after push and pop < DEPTH, else IDLE.
REQ-019 Latency: ack in cycle N -> entry visible with if_valid=1 in cycle N+1 when the FIFO was empty.
REQ-020 if_valid = FIFO not empty; a pop occurs when if_valid && if_ready; with push and pop in the same cycle, count is unchanged.
REQ-021 if_instr/if_pc hold stable while if_valid=1 and if_ready=0.
REQ-022 Redirect has highest priority: FIFO cleared (if_valid=0 next cycle); fetch_pc <= {redirect_pc[31:2],2'b00}; a pop in the same cycle is ignored.
REQ-023 Redirect in REQ without ack -> DISCARD; the old address is held until ack; that response is dropped; then go to REQ at the new fetch_pc.
REQ-024 Redirect in the cycle of an ack drops that response; the next state is REQ at the redirect address.
REQ-025 Redirect in DISCARD updates fetch_pc only; the FSM remains in DISCARD.
REQ-026 A FIFO overflow is impossible by construction; no push occurs when count == DEPTH.

Reset
REQ-027 While rst=0: state IDLE, fetch_pc=RESET_PC, FIFO empty, imem_req=0, if_valid=0; imem_addr, if_instr and if_pc are 0.
REQ-028 First imem_req=1 in the first rising edge after rst deasserts; a reset mid-request abandons it without waiting for ack.

Configuration
REQ-029 Macro INSTR_FETCH_PERF_EN: when defined, adds outputs perf_fetched[31:0] (responses pushed) and perf_discarded[31:0] (responses dropped), both reset to 0 and wrapping; when undefined, these ports and counters do not exist and behaviour is otherwise identical.

Structure
REQ-030 Package fetch_pkg holds XLEN=32, the FSM state enum, and the FIFO entry struct {pc, instr}.
REQ-031 Sub-module fetch_fifo (synchronous, DEPTH-parameterised, with push, pop, clear, count, and head outputs) implements the buffer; instr_fetch holds the FSM and fetch_pc.

Verification
REQ-032 Reset, imem_ack always 1, if_ready=1 -> imem_addr sequence 0,4,8,...; if_pc/if_instr match one per cycle after a one-cycle latency.
REQ-033 if_ready=0, ack always 1, DEPTH=4 -> exactly 4 pushes; imem_req stays 0 while full; if_pc=0 held; resume on if_ready=1 without loss.
REQ-034 Redirect to 0x100 while a request to 0x8 is outstanding and ack is delayed 3 cycles -> the 0x8 data is dropped; the next request is to 0x100; first if_pc=0x100.
REQ-035 Redirect in the same cycle as an ack -> the acked word never appears; if_valid=0 next cycle; the next request is to the redirect address.
REQ-036 redirect_pc=0xFFFF_FFFC, ack always 1 -> fetch addresses 0xFFFF_FFFC then 0x0000_0000; redirect_pc=0x103 -> request to 0x100.
REQ-037 With INSTR_FETCH_PERF_EN defined, scenario REQ-034 -> perf_discarded=1; perf_fetched equals the count of pushes.
